// File: rtl/sd_block_writer.sv
// sd_block_writer: SPI-mode SD card single-block writer (CMD24), streaming 512 payload bytes
// from a synchronous SRAM, then checking the data-response token and waiting out card busy.
module sd_block_writer #(
  parameter int CLK_DIV = 2,
  parameter int RESP_TIMEOUT = 8,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [31:0] block_addr,
  output logic [8:0]  buf_addr,
  input  logic [7:0]  din,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        cs,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);
  localparam int TMAX = RESP_TIMEOUT > BUSY_TIMEOUT ? RESP_TIMEOUT : BUSY_TIMEOUT;
  localparam int CW = $clog2(TMAX + 1) > 10 ? $clog2(TMAX + 1) : 10;
  localparam int DW = $clog2(CLK_DIV);
  typedef enum logic [3:0] {IDLE, PRE, CMD, R1, GAP, TOKEN, DATA, CRC, DRESP, BUSY, TAIL} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] addr;
  logic [7:0] tx, rx, nb;
  logic [DW-1:0] div;
  logic [2:0] bit_cnt, code_n;
  logic active, tick, rise, fall, byte_end, load;
  assign tick = active && div == DW'(CLK_DIV - 1);
  assign rise = tick && !sclk;
  assign fall = tick && sclk;
  assign byte_end = fall && bit_cnt == 3'd7;
  assign load = (state == IDLE && wr_req) || (byte_end && state != TAIL);
  assign ready = state == IDLE;
  assign cs = state == IDLE || state == TAIL;
  assign mosi = active ? tx[7] : 1'b1;
  // Next state is decided on the final falling edge so the next byte starts without a gap.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    code_n = 3'd0;
    case (state)
      IDLE: if (wr_req) begin
        state_n = PRE;
        cnt_n = '0;
      end
      PRE: if (byte_end) state_n = CMD;
      CMD: if (byte_end) begin
        state_n = cnt == CW'(5) ? R1 : CMD;
        cnt_n = cnt == CW'(5) ? '0 : cnt + 1'b1;
      end
      R1: if (byte_end) begin
        if (!rx[7]) begin
          state_n = rx == 8'h00 ? GAP : TAIL;
          code_n = rx == 8'h00 ? 3'd0 : 3'd1;
          cnt_n = '0;
        end else if (cnt >= CW'(RESP_TIMEOUT - 1)) begin
          state_n = TAIL;
          code_n = 3'd2;
        end else cnt_n = cnt + 1'b1;
      end
      GAP: if (byte_end) state_n = TOKEN;
      TOKEN: if (byte_end) begin
        state_n = DATA;
        cnt_n = '0;
      end
      DATA: if (byte_end) begin
        state_n = cnt == CW'(511) ? CRC : DATA;
        cnt_n = cnt == CW'(511) ? '0 : cnt + 1'b1;
      end
      CRC: if (byte_end) begin
        state_n = cnt == CW'(1) ? DRESP : CRC;
        cnt_n = cnt == CW'(1) ? '0 : cnt + 1'b1;
      end
      DRESP: if (byte_end) begin
        state_n = rx[4:0] == 5'h05 ? BUSY : TAIL;
        code_n = rx[4:0] == 5'h05 ? 3'd0 : 3'd3;
        cnt_n = '0;
      end
      BUSY: if (byte_end) begin
        if (rx == 8'hFF) state_n = TAIL;
        else if (cnt >= CW'(BUSY_TIMEOUT - 1)) begin
          state_n = TAIL;
          code_n = 3'd4;
        end else cnt_n = cnt + 1'b1;
      end
      TAIL: if (byte_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    nb = state_n == TOKEN ? 8'hFE : state_n == DATA ? din : 8'hFF;
    if (state_n == CMD)
      nb = cnt_n[2:0] == 3'd0 ? 8'h58 : cnt_n[2:0] == 3'd1 ? addr[31:24] :
           cnt_n[2:0] == 3'd2 ? addr[23:16] : cnt_n[2:0] == 3'd3 ? addr[15:8] :
           cnt_n[2:0] == 3'd4 ? addr[7:0] : 8'hFF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      tx <= 8'hFF;
      rx <= 8'h00;
      div <= '0;
      bit_cnt <= 3'd0;
      sclk <= 1'b0;
      active <= 1'b0;
      buf_addr <= 9'd0;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= 3'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      done <= state == TAIL && byte_end;
      if (state == IDLE && wr_req) begin
        addr <= block_addr;
        err <= 1'b0;
        err_code <= 3'd0;
      end else if (code_n != 3'd0) begin
        err <= 1'b1;
        err_code <= code_n;
      end
      // Address runs one whole byte ahead of the shifter, covering the SRAM read latency.
      if (load) begin
        tx <= nb;
        active <= 1'b1;
        div <= '0;
        bit_cnt <= 3'd0;
        sclk <= 1'b0;
        if (state_n == DATA) buf_addr <= cnt_n[8:0] + 9'd1;
      end else if (tick) begin
        div <= '0;
        sclk <= !sclk;
        if (rise) rx <= {rx[6:0], miso};
        if (fall) begin
          tx <= {tx[6:0], 1'b1};
          bit_cnt <= bit_cnt + 3'd1;
          active <= !byte_end;
        end
      end else if (active) div <= div + 1'b1;
    end
  end
endmodule
